tiny_soc_run_ctrl: RTL
======================

// Module: tiny_soc_run_ctrl
// PURPOSE
//  Synthesizable run controller observing the ariane_tiny_soc memory write port.
//  Decodes the magic-address writes for stop, trap, int-reg dump and fp-reg dump.
//  Sequences run -> drain -> done, and enforces a cycle budget.
//  Buffers register dumps in a small FIFO for a ready/valid consumer (UART/host bridge).
// PARAMETERS
//  ADDR_STOP    64'h00  stop-request address
//  ADDR_TRAP    64'h08  trap-signal address
//  ADDR_IDUMP   64'h10  integer register dump address
//  ADDR_FDUMP   64'h18  fp register dump address
//  DRAIN_CYCLES 50      cycles still run after a stop/trap detection
//  CNT_W        32      width of cycle budget and step counter
//  FIFO_DEPTH   4       dump FIFO entries, power of two, >=2
// PORTS
//  clk_i           in   1      clock
//  rst_i           in   1      synchronous, active-high reset
//  mem_req_i       in   1      SoC memory request
//  mem_we_i        in   1      write enable
//  mem_addr_i      in   64     byte address
//  mem_wdata_i     in   64     write data
//  simlen_i        in   CNT_W  cycle budget; 0 = unlimited; sampled each cycle
//  stop_on_trap_i  in   1      1: trap starts drain; 0: trap only flagged
//  dump_valid_o    out  1      FIFO head valid
//  dump_ready_i    in   1      consumer accepts head
//  dump_is_fp_o    out  1      head is fp reg (f) vs int reg (x)
//  dump_idx_o      out  6      register index of head
//  dump_data_o     out  64     register value of head
//  state_o         out  2      RUN=0, DRAIN=1, DONE=2
//  cause_o         out  2      NONE=0, STOP=1, TRAP=2, SIMLEN=3
//  trap_seen_o     out  1      sticky: any trap write observed
//  dump_ovf_o      out  1      sticky: dump dropped on full FIFO
//  done_o          out  1      level, high in DONE
// BEHAVIOUR
//  - Reset values: state RUN, cause NONE, all flags 0, FIFO empty, step=0.
//    Int index=1, fp index=0. Reset mid-operation aborts everything, including DONE.
//  - Hit: mem_req_i && mem_we_i && mem_addr_i==ADDR_x. Decoding is active in RUN only.
//    In DRAIN and DONE, writes are ignored (no dumps, no flags).
//  - STOP hit in RUN: next state DRAIN, cause STOP, drain counter <= DRAIN_CYCLES.
//  - TRAP hit in RUN: trap_seen_o <= 1.
//    If stop_on_trap_i, go to DRAIN with cause TRAP; else stay in RUN.
//  - DRAIN: counter decrements every cycle.
//    Detection at cycle t gives done_o=1 from t+DRAIN_CYCLES+1.
//  - Step counter increments every RUN/DRAIN cycle, starting at 0 on the first cycle after reset.
//    If simlen_i!=0 and step==simlen_i-1: next state DONE.
//    Cause becomes SIMLEN only if it is still NONE.
//    The budget check outranks a same-cycle STOP/TRAP hit: go to DONE, cause records the hit.
//  - DONE is absorbing until rst_i; step freezes.
//  - IDUMP hit: push {0, int_idx, wdata}; int_idx++ (6-bit, wraps 63->0).
//    FDUMP hit: push {1, fp_idx, wdata}; fp_idx++ (wraps).
//  - Index increments even when the push is dropped.
//  - Push latency: entry visible on dump_valid_o the cycle after the hit, when the FIFO was empty.
//  - Pop on dump_valid_o && dump_ready_i. Outputs stable while valid && !ready.
//  - Full FIFO: a push is accepted if a pop occurs in the same cycle.
//    Otherwise the push is dropped and dump_ovf_o <= 1 (sticky).
//  - FIFO keeps draining in DRAIN/DONE.
//  - Address decode is mutually exclusive; non-matching writes and reads are ignored.
// STRUCTURE
//  - tiny_soc_pkg:
//    ADDR_* constants, run_state_e, run_cause_e,
//    dump_entry_t {logic is_fp; logic [5:0] idx; logic [63:0] data}.
//  - Sub-module run_ctrl_fifo: sync FIFO of dump_entry_t with ptr+1 wrap bits,
//    full/empty flags and same-cycle push/pop when full.
//  - Top: decode, FSM, step/drain counters, index counters, sticky flags.
// TESTING
//  - Reset, then IDUMP writes 0xA, 0xB with ready=1
//    -> entries {0,1,0xA}, {0,2,0xB}, each one cycle after its hit.
//  - STOP write at cycle 100, DRAIN_CYCLES=50
//    -> state DRAIN at 101, done_o at 151, cause STOP; an IDUMP at 120 is ignored.
//  - TRAP with stop_on_trap_i=0 -> trap_seen_o=1, state stays RUN.
//    Second TRAP with stop_on_trap_i=1 -> DRAIN, cause TRAP.
//  - simlen_i=20, no writes -> done_o from cycle 20 (step 19 is last), cause SIMLEN.
//    STOP hit at step 19 -> DONE, cause STOP.
//  - ready=0, 5 FDUMP writes, depth 4 -> 4 entries idx 0..3, dump_ovf_o=1.
//    Next FDUMP has idx 5.
//  - Full FIFO with push and pop in the same cycle -> no overflow, count stays 4.
//    rst_i mid-DRAIN -> RUN, FIFO empty.

Source files
------------

// File: rtl/tiny_soc_pkg.sv
// Shared constants and types for the ariane_tiny_soc run controller.
package tiny_soc_pkg;

    localparam logic [63:0] ADDR_STOP  = 64'h00;
    localparam logic [63:0] ADDR_TRAP  = 64'h08;
    localparam logic [63:0] ADDR_IDUMP = 64'h10;
    localparam logic [63:0] ADDR_FDUMP = 64'h18;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } run_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_STOP   = 2'd1,
        CAUSE_TRAP   = 2'd2,
        CAUSE_SIMLEN = 2'd3
    } run_cause_e;

    typedef struct packed {
        logic        is_fp;
        logic [5:0]  idx;
        logic [63:0] data;
    } dump_entry_t;

endpackage

// File: rtl/tiny_soc_run_ctrl_fifo.sv
// Synchronous FIFO of register-dump entries; a push into a full FIFO is taken if a pop happens the same cycle.
module run_ctrl_fifo
    import tiny_soc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  dump_entry_t push_entry,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output dump_entry_t head,
    output logic        drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    dump_entry_t  mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/tiny_soc_run_ctrl.sv
// Run controller for ariane_tiny_soc: magic-address decode, run/drain/done sequencing,
// cycle budget and a buffered register-dump stream.
module tiny_soc_run_ctrl #(
    parameter logic [63:0] ADDR_STOP    = tiny_soc_pkg::ADDR_STOP,
    parameter logic [63:0] ADDR_TRAP    = tiny_soc_pkg::ADDR_TRAP,
    parameter logic [63:0] ADDR_IDUMP   = tiny_soc_pkg::ADDR_IDUMP,
    parameter logic [63:0] ADDR_FDUMP   = tiny_soc_pkg::ADDR_FDUMP,
    parameter int unsigned DRAIN_CYCLES = 50,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_req_i,
    input  logic             mem_we_i,
    input  logic [63:0]      mem_addr_i,
    input  logic [63:0]      mem_wdata_i,
    input  logic [CNT_W-1:0] simlen_i,
    input  logic             stop_on_trap_i,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic             dump_is_fp_o,
    output logic [5:0]       dump_idx_o,
    output logic [63:0]      dump_data_o,
    output logic [1:0]       state_o,
    output logic [1:0]       cause_o,
    output logic             trap_seen_o,
    output logic             dump_ovf_o,
    output logic             done_o
);

    import tiny_soc_pkg::*;

    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 2);

    run_state_e       state;
    run_cause_e       cause;
    logic             done;
    logic [DW-1:0]    drain_cnt;
    logic [CNT_W-1:0] step;
    logic [5:0]       int_idx;
    logic [5:0]       fp_idx;
    logic             trap_seen;
    logic             dump_ovf;

    logic             wr_run;
    logic             hit_stop;
    logic             hit_trap;
    logic             hit_idump;
    logic             hit_fdump;
    logic             trap_stops;
    logic             budget_hit;

    dump_entry_t      push_entry;
    dump_entry_t      head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    logic             pop;

    assign wr_run     = mem_req_i && mem_we_i && (state == RUN);
    assign hit_stop   = wr_run && (mem_addr_i == ADDR_STOP);
    assign hit_trap   = wr_run && (mem_addr_i == ADDR_TRAP);
    assign hit_idump  = wr_run && (mem_addr_i == ADDR_IDUMP);
    assign hit_fdump  = wr_run && (mem_addr_i == ADDR_FDUMP);
    assign trap_stops = hit_trap && stop_on_trap_i;
    assign budget_hit = (simlen_i != '0) && (step == simlen_i - CNT_W'(1));

    // Budget expiry wins over a same-cycle stop/trap, but the cause still names the hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            cause     <= CAUSE_NONE;
            done      <= 1'b0;
            drain_cnt <= '0;
            step      <= '0;
        end else begin
            case (state)
                RUN: begin
                    step <= step + CNT_W'(1);
                    if (budget_hit) begin
                        state <= DONE;
                        done  <= 1'b1;
                        cause <= hit_stop   ? CAUSE_STOP :
                                 trap_stops ? CAUSE_TRAP : CAUSE_SIMLEN;
                    end else if (hit_stop || trap_stops) begin
                        state     <= (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                        done      <= (DRAIN_CYCLES == 0);
                        cause     <= hit_stop ? CAUSE_STOP : CAUSE_TRAP;
                        drain_cnt <= DW'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    step      <= step + CNT_W'(1);
                    drain_cnt <= drain_cnt - DW'(1);
                    if (budget_hit || drain_cnt <= DW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            int_idx   <= 6'd1;
            fp_idx    <= 6'd0;
            trap_seen <= 1'b0;
            dump_ovf  <= 1'b0;
        end else begin
            if (hit_idump) int_idx <= int_idx + 6'd1;
            if (hit_fdump) fp_idx  <= fp_idx + 6'd1;
            if (hit_trap)  trap_seen <= 1'b1;
            if (fifo_drop) dump_ovf  <= 1'b1;
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.is_fp = hit_fdump;
        push_entry.idx   = hit_fdump ? fp_idx : int_idx;
        push_entry.data  = mem_wdata_i;
    end

    assign pop = !fifo_empty && dump_ready_i;

    run_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (hit_idump || hit_fdump),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head),
        .drop       (fifo_drop)
    );

    assign dump_valid_o = !fifo_empty;
    assign dump_is_fp_o = head.is_fp;
    assign dump_idx_o   = head.idx;
    assign dump_data_o  = head.data;
    assign state_o      = state;
    assign cause_o      = cause;
    assign trap_seen_o  = trap_seen;
    assign dump_ovf_o   = dump_ovf;
    assign done_o       = done;

endmodule
